audio_iir1_filter: RTL and testbench

- Parametrised first-order IIR filter for the codec path: N channels of W-bit signed samples, run-time mode (high-pass / low-pass / bypass / mute) and run-time coefficient.
- Sits between the ADC deserialiser and the DAC serialiser, clocked by AUD_BCLK.
- Processes one frame per rising edge of AUD_DACLRCK, using one shared multiplier time-multiplexed across channels.
- Output is registered and saturated, with a valid pulse and an overrun flag.

---
 rtl/audio_iir1_filter_pkg.sv | 31 +++
 rtl/audio_iir1_filter_mac.sv | 42 ++++
 rtl/audio_iir1_filter.sv | 146 ++++++++++++++
 tb/tb_audio_iir1_filter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/audio_iir1_filter_pkg.sv
// Shared mode codes, FSM encoding and the saturation helper for the IIR filter.
package audio_filt_pkg;

  localparam logic [1:0] MODE_HPF  = 2'd0;
  localparam logic [1:0] MODE_LPF  = 2'd1;
  localparam logic [1:0] MODE_BYP  = 2'd2;
  localparam logic [1:0] MODE_MUTE = 2'd3;

  // Frame capture happens on the IDLE->PRE transition, so no separate latch state is needed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRE    = 2'd1,
    ST_MUL    = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam int SAT_IN_W = 64;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [SAT_IN_W-1:0] sat_w(input logic signed [SAT_IN_W-1:0] v,
                                                      input int w);
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/audio_iir1_filter_mac.sv
// Shared multiply / shift / saturate unit: operands registered in PRE, result valid in MUL.
module iir1_mac
  import audio_filt_pkg::*;
#(
  parameter int W         = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 15
) (
  input  logic                AUD_BCLK,
  input  logic                rst,
  input  logic                ld_i,
  input  logic signed [W+1:0] d_i,
  input  logic signed [W-1:0] base_i,
  input  logic [COEF_W-1:0]   coef_i,
  output logic signed [W-1:0] y_o
);

  // Wide enough for |d| < 3*2^(W-1) times an unsigned coefficient, so nothing wraps.
  localparam int P_W = W + COEF_W + 2;

  logic signed [W+1:0] d_q;
  logic signed [W-1:0] base_q;
  logic signed [P_W-1:0] d_x, c_x, p, q, y;

  // Capture the channel operand and its accumulation base.
  always_ff @(posedge AUD_BCLK or negedge rst)
    if (!rst) begin
      d_q    <= '0;
      base_q <= '0;
    end else if (ld_i) begin
      d_q    <= d_i;
      base_q <= base_i;
    end

  assign d_x = P_W'(d_q);
  assign c_x = P_W'(coef_i);
  assign p   = d_x * c_x;
  assign q   = p >>> COEF_FRAC;
  assign y   = q + P_W'(base_q);
  assign y_o = W'(sat_w(SAT_IN_W'(y), W));

endmodule

// File: rtl/audio_iir1_filter.sv
// First-order IIR (HPF/LPF/bypass/mute) over CH channels, one shared MAC, one frame per LRCK rise.
module audio_iir1_filter
  import audio_filt_pkg::*;
#(
  parameter int W         = 16,
  parameter int CH        = 2,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 15
) (
  input  logic                AUD_BCLK,
  input  logic                rst,
  input  logic                AUD_DACLRCK,
  input  logic [CH*W-1:0]     audio_in,
  input  logic [1:0]          mode,
  input  logic [COEF_W-1:0]   coef,
  input  logic                clr_overrun,
  output logic [CH*W-1:0]     audio_out,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    lrck_q, start;
  logic [CH-1:0][W-1:0]    in_ch, x_q, x1_q, y1_q, shadow_q, out_q;
  logic [1:0]              mode_q, last_mode_q;
  logic [COEF_W-1:0]       coef_q;
  logic                    out_valid_q, overrun_q;
  logic signed [W-1:0]     xs, x1s, y1s, mac_y, y_ch;
  logic signed [W+1:0]     d_op;

  // Channel 0 sits in the MSBs of the packed bus.
  for (genvar k = 0; k < CH; k++) begin : g_pack
    assign in_ch[k]                   = audio_in[(CH-k)*W-1 -: W];
    assign audio_out[(CH-k)*W-1 -: W] = out_q[k];
  end

  assign start = AUD_DACLRCK & ~lrck_q;
  assign xs    = x_q[ch_q];
  assign x1s   = x1_q[ch_q];
  assign y1s   = y1_q[ch_q];

  // LPF integrates the error against y1; HPF feeds y1 + (x - x1) straight through alpha.
  assign d_op = (mode_q == MODE_LPF) ? ((W+2)'(xs) - (W+2)'(y1s))
                                     : ((W+2)'(y1s) + (W+2)'(xs) - (W+2)'(x1s));

  iir1_mac #(.W(W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC)) u_mac (
    .AUD_BCLK (AUD_BCLK),
    .rst      (rst),
    .ld_i     (state_q == ST_PRE),
    .d_i      (d_op),
    .base_i   ((mode_q == MODE_LPF) ? y1s : '0),
    .coef_i   (coef_q),
    .y_o      (mac_y)
  );

  // Bypass/mute reuse the MUL slot so latency is the same in every mode.
  always_comb begin
    y_ch = mac_y;
    case (mode_q)
      MODE_BYP:  y_ch = xs;
      MODE_MUTE: y_ch = '0;
      default:   ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge AUD_BCLK or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end

  // Next state: PRE/MUL pair per channel, then a single COMMIT cycle.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_PRE;
        ch_d    = '0;
      end
      ST_PRE:  state_d = ST_MUL;
      ST_MUL:  if (ch_q == CH_W'(CH - 1)) state_d = ST_COMMIT;
               else begin
                 state_d = ST_PRE;
                 ch_d    = ch_q + 1'b1;
               end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Frame capture, history/shadow update, output commit and overrun tracking.
  always_ff @(posedge AUD_BCLK or negedge rst)
    if (!rst) begin
      lrck_q      <= 1'b0;
      x_q         <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      shadow_q    <= '0;
      out_q       <= '0;
      mode_q      <= MODE_HPF;
      last_mode_q <= MODE_HPF;
      coef_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      lrck_q      <= AUD_DACLRCK;
      out_valid_q <= 1'b0;
      if (state_q == ST_IDLE && start) begin
        x_q         <= in_ch;
        mode_q      <= mode;
        coef_q      <= coef;
        last_mode_q <= mode;
        // Stale history from another mode would produce a transient; start clean.
        if (mode != last_mode_q) begin
          x1_q <= '0;
          y1_q <= '0;
        end
      end
      if (state_q == ST_MUL) begin
        y1_q[ch_q]     <= y_ch;
        x1_q[ch_q]     <= x_q[ch_q];
        shadow_q[ch_q] <= y_ch;
      end
      if (state_q == ST_COMMIT) begin
        out_q       <= shadow_q;
        out_valid_q <= 1'b1;
      end
      // A new edge while busy is dropped; setting wins over a same-cycle clear.
      if (start && state_q != ST_IDLE) overrun_q <= 1'b1;
      else if (clr_overrun)            overrun_q <= 1'b0;
    end

  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_iir1_filter.sv
// Directed bench for audio_iir1_filter with hand-computed expected samples.
module tb_audio_iir1_filter;
  import audio_filt_pkg::*;

  localparam int W = 16, CH = 2, COEF_W = 16;

  logic              AUD_BCLK = 1'b0;
  logic              rst = 1'b0;
  logic              AUD_DACLRCK = 1'b0;
  logic              clr_overrun = 1'b0;
  logic [CH*W-1:0]   audio_in = '0;
  logic [1:0]        mode = MODE_HPF;
  logic [COEF_W-1:0] coef = '0;
  logic [CH*W-1:0]   audio_out;
  logic              out_valid, busy, overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 AUD_BCLK = ~AUD_BCLK;

  audio_iir1_filter #(.W(W), .CH(CH), .COEF_W(COEF_W), .COEF_FRAC(15)) dut (
    .AUD_BCLK    (AUD_BCLK),
    .rst         (rst),
    .AUD_DACLRCK (AUD_DACLRCK),
    .audio_in    (audio_in),
    .mode        (mode),
    .coef        (coef),
    .clr_overrun (clr_overrun),
    .audio_out   (audio_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // One frame: raise LRCK, check busy, latency, both channels and the single-cycle valid pulse.
  // With ovr set, a second LRCK edge arrives two cycles after latch carrying junk inputs.
  task automatic frame(input string tag, input logic [1:0] m, input logic [15:0] c,
                       input int l, input int r, input bit ovr, input int el, input int er);
    int lat;
    @(negedge AUD_BCLK);
    mode = m; coef = c; audio_in = {16'(l), 16'(r)}; AUD_DACLRCK = 1'b1;
    @(posedge AUD_BCLK); #1;
    chk({tag, "_busy"}, busy, 1);
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge AUD_BCLK);
      if (n == 0) AUD_DACLRCK = 1'b0;
      if (ovr && n == 1) begin
        AUD_DACLRCK = 1'b1; audio_in = {16'sd30000, 16'sd30000}; mode = MODE_HPF; coef = '1;
      end
      if (ovr && n == 2) AUD_DACLRCK = 1'b0;
      @(posedge AUD_BCLK); #1;
      if (out_valid) begin lat = n + 1; break; end
    end
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_L"}, $signed(audio_out[31:16]), el);
    chk({tag, "_R"}, $signed(audio_out[15:0]), er);
    @(posedge AUD_BCLK); #1;
    chk({tag, "_vld_drop"}, out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    repeat (3) @(posedge AUD_BCLK); #1;
    chk("rst_out", audio_out, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    @(negedge AUD_BCLK); rst = 1'b1;

    // HPF step, alpha ~ 2/3
    frame("hpf1", MODE_HPF, 16'h5555, 1000, 0, 0, 666, 0);
    frame("hpf2", MODE_HPF, 16'h5555, 1000, 0, 0, 443, 0);
    // LPF step, alpha = 1/2, on the right channel
    frame("lpf1", MODE_LPF, 16'h4000, 0, 1000, 0, 0, 500);
    frame("lpf2", MODE_LPF, 16'h4000, 0, 1000, 0, 0, 750);
    frame("lpf3", MODE_LPF, 16'h4000, 0, 1000, 0, 0, 875);
    // HPF negative step floors toward -inf
    frame("hpfneg", MODE_HPF, 16'h5555, -1000, -1000, 0, -667, -667);
    frame("mute", MODE_MUTE, 16'h5555, 1234, -1234, 0, 0, 0);
    // Full-scale swing and saturation at both rails
    frame("fs1", MODE_HPF, 16'h7FFF, -32768, 0, 0, -32767, 0);
    frame("fs2", MODE_HPF, 16'h7FFF, 32767, 0, 0, 32767, 0);
    frame("sat", MODE_HPF, 16'hFFFF, -32768, 20000, 0, -32768, 32767);
    // Mode switch clears history
    frame("byp", MODE_BYP, 16'h5555, 1000, -5, 0, 1000, -5);
    frame("hpf_re", MODE_HPF, 16'h5555, 1000, 0, 0, 666, 0);
    // coef = 0: HPF gives 0, LPF holds its state
    frame("hpf_c0", MODE_HPF, 16'h0000, 500, 700, 0, 0, 0);
    frame("lpf_a", MODE_LPF, 16'h4000, 0, 1000, 0, 0, 500);
    frame("lpf_c0", MODE_LPF, 16'h0000, 0, 2000, 0, 0, 500);

    // Overrun: second edge dropped, result reflects the first frame only
    frame("ovr", MODE_LPF, 16'h4000, 0, 1000, 1, 0, 750);
    chk("ovr_flag", overrun, 1);
    pulses = 0;
    repeat (12) begin @(posedge AUD_BCLK); #1; if (out_valid) pulses++; end
    chk("ovr_nopulse", pulses, 0);
    chk("ovr_hold", $signed(audio_out[15:0]), 750);
    @(negedge AUD_BCLK); clr_overrun = 1'b1;
    @(posedge AUD_BCLK); #1;
    chk("ovr_clr", overrun, 0);
    @(negedge AUD_BCLK); clr_overrun = 1'b0;

    // Reset during MUL of ch0 in a same-mode LPF frame
    @(negedge AUD_BCLK);
    mode = MODE_LPF; coef = 16'h4000; audio_in = {16'sd100, 16'sd100}; AUD_DACLRCK = 1'b1;
    @(posedge AUD_BCLK);
    @(negedge AUD_BCLK); AUD_DACLRCK = 1'b0;
    @(posedge AUD_BCLK);
    @(negedge AUD_BCLK); rst = 1'b0;
    #1;
    chk("mrst_out", audio_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_vld", out_valid, 0);
    pulses = 0;
    repeat (2) begin @(posedge AUD_BCLK); #1; if (out_valid) pulses++; end
    @(negedge AUD_BCLK); rst = 1'b1;
    repeat (10) begin @(posedge AUD_BCLK); #1; if (out_valid) pulses++; end
    chk("mrst_nopulse", pulses, 0);
    frame("post_rst", MODE_HPF, 16'h5555, 1000, 0, 0, 666, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
